// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 encodings for load/store width and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a word-aligned read and extends it.
// Latency: combinational.
// Backpressure: none.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Shift the selected lane down to bit 0; half lanes only look at addr[1]
  // so a misaligned halfword collapses onto its aligned lane.
  always_comb begin
    byte_sh = rdata_i >> {addr_lo_i, 3'b000};
    half_sh = rdata_i >> {addr_lo_i[1], 4'b0000};
  end

  // Extend according to width/sign; unknown encodings behave as a full word.
  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      F3_H:    data_o = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU results pass through, loads/stores go over a req/resp port.
// Latency: ALU 1 cycle, store >=2, load >=3 from accept; one access in flight.
// Backpressure: in_ready low while an access is outstanding (REQ/WAIT).
// Optional: define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int MASK_W = XLEN/8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [4:0]        in_rd,
  input  logic              in_reg_we,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  state_e state_q, state_d;

  logic              acc, is_mem, trap;
  logic              sz_b, sz_h, sz_w;
  logic [1:0]        a_in;
  logic [MASK_W-1:0] st_mask;
  logic [XLEN-1:0]   st_data;

  logic [MASK_W-1:0] wmask_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [1:0]        addr_lo_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              reg_we_q, store_q;

  logic              wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [XLEN-1:0]   load_val;

  // Decode the incoming instruction; funct3[1:0]==11 is treated as a word.
  always_comb begin
    acc    = in_valid && (state_q == IDLE);
    is_mem = in_is_load || in_is_store;
    a_in   = in_result[1:0];
    sz_b   = (in_funct3[1:0] == 2'b00);
    sz_h   = (in_funct3[1:0] == 2'b01);
    sz_w   = !sz_b && !sz_h;
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap = acc && is_mem &&
                ((sz_h && a_in[0]) || (sz_w && (a_in != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Store lane placement: replicate the datum, enable only the addressed lanes.
  always_comb begin
    st_mask = '1;
    st_data = in_store_data;
    if (sz_b) begin
      st_mask = MASK_W'(1) << a_in;
      st_data = {MASK_W{in_store_data[7:0]}};
    end else if (sz_h) begin
      st_mask = MASK_W'(2'b11) << {a_in[1], 1'b0};
      st_data = {(XLEN/16){in_store_data[15:0]}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a store counts even if in_is_load is also set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc && is_mem && !trap) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = store_q ? IDLE : WAIT;
      WAIT:    if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready      = (state_q == IDLE);
    mem_req_valid = (state_q == REQ);
  end

  // Capture the access on accept; these drive the memory port unchanged until done.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      addr_lo_q <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      reg_we_q  <= 1'b0;
      store_q   <= 1'b0;
    end else if (acc && is_mem && !trap) begin
      addr_q    <= {in_result[XLEN-1:2], 2'b00};
      wmask_q   <= in_is_store ? st_mask : '0;
      wdata_q   <= in_is_store ? st_data : '0;
      addr_lo_q <= a_in;
      f3_q      <= in_funct3;
      rd_q      <= in_rd;
      reg_we_q  <= in_reg_we;
      store_q   <= in_is_store;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (f3_q),
    .data_o    (load_val)
  );

  // Writeback next state; wb_data holds between pulses for forwarding.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        if (trap) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = in_rd;
          wb_data_d  = in_result;
        end else if (acc && !is_mem) begin
          wb_valid_d = 1'b1;
          wb_we_d    = in_reg_we && (in_rd != 5'd0);
          wb_rd_d    = in_rd;
          wb_data_d  = in_result;
        end
      end
      REQ: begin
        if (mem_req_ready && store_q) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = reg_we_q && (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = load_val;
        end
      end
      default: ;
    endcase
  end

  // Writeback registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misalign_q;
  // One-cycle flag alongside the trap writeback.
  always_ff @(posedge clk) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= trap;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign mem_addr  = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized loads/stores/ALU ops
// checked against an arithmetic model of lane placement and extension.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_result, in_store_data;
  logic [2:0]  in_funct3;
  logic        in_is_load, in_is_store;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_store_data(in_store_data),
    .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_rd(in_rd), .in_reg_we(in_reg_we),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_load(logic [31:0] rdw, logic [31:0] addr, logic [2:0] f3);
    int unsigned a, b, h;
    a = addr % 4;
    b = (rdw >> (8 * a)) & 32'hFF;
    h = (rdw >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return rdw;
    endcase
  endfunction

  function automatic logic [3:0] exp_mask(logic [31:0] addr, logic [2:0] f3);
    int unsigned a;
    a = addr % 4;
    if (f3 == 3'd0) return 4'(1 << a);
    if (f3 == 3'd1) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(logic [31:0] d, logic [2:0] f3);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Width class: byte for 0/4, half for 1/5, otherwise word.
  function automatic bit exp_trap(logic [31:0] addr, logic [2:0] f3);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    int unsigned a;
    a = addr % 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    return a != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(logic [31:0] res, logic [31:0] sd, logic [2:0] f3,
                          logic ld, logic st, logic [4:0] rd, logic we);
    in_valid      = 1'b1;
    in_result     = res;
    in_store_data = sd;
    in_funct3     = f3;
    in_is_load    = ld;
    in_is_store   = st;
    in_rd         = rd;
    in_reg_we     = we;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++;
    if ({mem_req_valid, mem_wmask, wb_valid, wb_we, wb_rd, misalign} !== 13'd0)
      $display("FAIL reset_ctrl got %b want 0", {mem_req_valid, mem_wmask, wb_valid, wb_we, wb_rd, misalign});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, wb_data} !== 96'd0)
      $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, wb_data);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu_stream();
    logic [31:0] res [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [4:0]  rds [4] = '{5'd5, 5'd6, 5'd7, 5'd0};
    for (int i = 0; i < 4; i++) begin
      drive_in(res[i], 32'h0, 3'd0, 1'b0, 1'b0, rds[i], 1'b1);
      tick();
      n_checks++;
      if ({in_ready, wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, rds[i] != 5'd0, rds[i], res[i]})
        $display("FAIL alu_%0d got rdy=%b v=%b we=%b rd=%0d d=%h want rdy=1 v=1 we=%b rd=%0d d=%h",
                 i, in_ready, wb_valid, wb_we, wb_rd, wb_data, rds[i] != 5'd0, rds[i], res[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL alu_idle wb_valid got %b want 0", wb_valid); else n_pass++;
    n_checks++; if (wb_data !== 32'h44) $display("FAIL alu_hold wb_data got %h want 44", wb_data); else n_pass++;
  endtask

  task automatic test_store_sb();
    drive_in(32'h0000_1003, 32'hAABB_CCDD, 3'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({mem_req_valid, in_ready, wb_valid, mem_addr, mem_wmask, mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD})
      $display("FAIL sb_req got v=%b rdy=%b wb=%b a=%h m=%b d=%h want 1 0 0 1000 1000 dddddddd",
               mem_req_valid, in_ready, wb_valid, mem_addr, mem_wmask, mem_wdata);
    else n_pass++;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    n_checks++;
    if ({wb_valid, wb_we, in_ready, mem_req_valid} !== 4'b1010)
      $display("FAIL sb_done got v=%b we=%b rdy=%b req=%b want 1 0 1 0", wb_valid, wb_we, in_ready, mem_req_valid);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  offs[5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
    logic [31:0] exps[5] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_80F0, 32'h0000_80F0, 32'h80F0_7F81};
    for (int i = 0; i < 5; i++) begin
      drive_in(32'h3000 + 32'(offs[i]), 32'h0, f3s[i], 1'b1, 1'b0, 5'd3, 1'b1);
      tick();
      in_valid = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h80F0_7F81;
      tick();
      mem_resp_valid = 1'b0;
      n_checks++;
      if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd3, exps[i]})
        $display("FAIL load_%0d got v=%b we=%b rd=%0d d=%h want v=1 we=1 rd=3 d=%h",
                 i, wb_valid, wb_we, wb_rd, wb_data, exps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] addr;
    int pulses;
    bit  bad;
    addr   = {$urandom} & 32'hFFFF_FFFC;
    pulses = 0;
    bad    = 1'b0;
    drive_in(addr, $urandom, 3'd2, 1'b1, 1'b0, 5'd12, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!(mem_req_valid === 1'b1 && mem_addr === addr && mem_wmask === 4'd0 && in_ready === 1'b0)) bad = 1'b1;
      if (wb_valid === 1'b1) pulses++;
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready !== 1'b0 || mem_req_valid !== 1'b0) bad = 1'b1;
      if (wb_valid === 1'b1) pulses++;
      if (i == 2) begin
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
      end
      tick();
    end
    mem_resp_valid = 1'b0;
    n_checks++; if (bad) $display("FAIL bp_stable got unstable request/ready want stable"); else n_pass++;
    n_checks++;
    if (wb_data !== 32'hCAFE_F00D || wb_valid !== 1'b1)
      $display("FAIL bp_data got v=%b d=%h want v=1 d=cafef00d", wb_valid, wb_data);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 1) $display("FAIL bp_pulses got %0d want 1", pulses); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    drive_in(32'h5004, 32'h0, 3'd2, 1'b1, 1'b0, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({mem_req_valid, mem_wmask, wb_valid, wb_we, wb_rd, misalign, mem_addr, mem_wdata, wb_data} !== '0 ||
        in_ready !== 1'b1)
      $display("FAIL rst_mid got rdy=%b req=%b a=%h wbd=%h want rdy=1 all-zero", in_ready, mem_req_valid, mem_addr, wb_data);
    else n_pass++;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++;
    if ({wb_valid, in_ready, mem_req_valid} !== 3'b010)
      $display("FAIL rst_late_resp got v=%b rdy=%b req=%b want 0 1 0", wb_valid, in_ready, mem_req_valid);
    else n_pass++;
    tick();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL rst_no_wb got %b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_misalign();
    drive_in(32'h2002, 32'h0, 3'd2, 1'b1, 1'b0, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    n_checks++;
    if ({mem_req_valid, misalign, wb_valid, wb_we, in_ready, wb_data} !== {5'b01101, 32'h2002})
      $display("FAIL mis_trap got req=%b mis=%b v=%b we=%b rdy=%b d=%h want 0 1 1 0 1 2002",
               mem_req_valid, misalign, wb_valid, wb_we, in_ready, wb_data);
    else n_pass++;
    tick();
    n_checks++; if (misalign !== 1'b0) $display("FAIL mis_pulse got %b want 0", misalign); else n_pass++;
`else
    n_checks++;
    if ({mem_req_valid, misalign, mem_addr} !== {2'b10, 32'h2000})
      $display("FAIL mis_force got req=%b mis=%b a=%h want 1 0 2000", mem_req_valid, misalign, mem_addr);
    else n_pass++;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0BAD_BEEF;
    tick();
    mem_resp_valid = 1'b0;
    n_checks++;
    if (wb_data !== 32'h0BAD_BEEF) $display("FAIL mis_force_data got %h want 0badbeef", wb_data); else n_pass++;
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          kind;
      logic [31:0] addr, sd, rdw;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        we, ld, st, trp;
      kind = $urandom_range(0, 3);
      addr = $urandom;
      sd   = $urandom;
      rdw  = $urandom;
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      we   = 1'($urandom_range(0, 1));
      ld   = (kind == 1) || (kind == 3);
      st   = (kind >= 2);
      f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      trp  = (kind != 0) && exp_trap(addr, f3);
      drive_in(addr, sd, f3, ld, st, rd, we);
      tick();
      in_valid = 1'b0;
      if (kind == 0 || trp) begin
        n_checks++;
        if ({wb_valid, wb_we, wb_data, misalign, mem_req_valid} !==
            {1'b1, (kind == 0) && we && (rd != 5'd0), addr, trp, 1'b0})
          $display("FAIL rnd_%0d_direct got v=%b we=%b d=%h mis=%b req=%b want trap=%b addr=%h",
                   n, wb_valid, wb_we, wb_data, misalign, mem_req_valid, trp, addr);
        else n_pass++;
      end else begin
        n_checks++;
        if ({mem_req_valid, in_ready, wb_valid, mem_addr, mem_wmask} !==
            {3'b100, addr & 32'hFFFF_FFFC, st ? exp_mask(addr, f3) : 4'd0} ||
            (st && mem_wdata !== exp_wdata(sd, f3)))
          $display("FAIL rnd_%0d_req got a=%h m=%b d=%h want a=%h m=%b d=%h", n, mem_addr, mem_wmask,
                   mem_wdata, addr & 32'hFFFF_FFFC, st ? exp_mask(addr, f3) : 4'd0, exp_wdata(sd, f3));
        else n_pass++;
        repeat ($urandom_range(0, 2)) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if (!st) begin
          repeat ($urandom_range(0, 2)) tick();
          mem_resp_valid = 1'b1;
          mem_rdata = rdw;
          tick();
          mem_resp_valid = 1'b0;
        end
        n_checks++;
        if ({wb_valid, wb_we, in_ready} !== {1'b1, !st && we && (rd != 5'd0), 1'b1} ||
            (!st && wb_data !== exp_load(rdw, addr, f3)))
          $display("FAIL rnd_%0d_wb got v=%b we=%b d=%h want we=%b d=%h", n, wb_valid, wb_we, wb_data,
                   !st && we && (rd != 5'd0), exp_load(rdw, addr, f3));
        else n_pass++;
      end
    end
  endtask

  initial begin
    in_valid = 1'b0; in_result = '0; in_store_data = '0; in_funct3 = '0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_rd = '0; in_reg_we = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    reset = 1'b1;
    test_reset();
    test_alu_stream();
    test_store_sb();
    test_loads();
    test_backpressure();
    test_reset_mid_access();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
